fft_twiddle_mult: RTL and testbench

Twiddle-multiply stage of the 1024-point radix-2 DIT FFT. Sits between the butterfly data path and the twiddle-factor ROM. Counts butterflies within a stage, drives the ROM address, and multiplies each incoming lower-leg sample by the returned twiddle. Produces a rounded, saturated complex result with a fixed 3-cycle latency and no backpressure.

---
 rtl/fft_twiddle_mult_pkg.sv | 48 ++++
 rtl/fft_twiddle_mult_cmul_round.sv | 118 +++++++++++
 rtl/fft_twiddle_mult.sv | 145 ++++++++++++++
 tb/tb_fft_twiddle_mult.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_twiddle_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_twiddle_mult_pkg
//  Description : Shared constants and helpers for the FFT twiddle-multiply
//                stage. It sets the default word width and FFT size, and
//                defines the rounding constant, the saturation bounds and the
//                stage-index clamp.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package fft_twiddle_mult_pkg;

  // Default sample/twiddle width (Q1.(WIDTH-1)) and log2 of the FFT size.
  localparam int c_width_dflt  = 16;
  localparam int c_n_log2_dflt = 10;

  // Width of the stage-index field on the interface.
  localparam int c_stage_w = 4;

  // Half an LSB of the final Q1.(w-1) result, expressed at product scale.
  // Adding it before the arithmetic shift gives round-half-up.
  function automatic longint f_round_c(input int w);
    return longint'(1) << (w - 2);
  endfunction

  // Largest positive w-bit two's-complement value.
  function automatic longint f_sat_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  // Most negative w-bit two's-complement value.
  function automatic longint f_sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  // Out-of-range stage indices map to the last stage.
  function automatic logic [c_stage_w-1:0] f_clamp_stage(
    input logic [c_stage_w-1:0] s,
    input int                   max_s
  );
    if (int'(s) > max_s) begin
      return c_stage_w'(max_s);
    end
    return s;
  endfunction

endpackage : fft_twiddle_mult_pkg
`default_nettype wire

// File: rtl/fft_twiddle_mult_cmul_round.sv
`default_nettype none
// ============================================================================
//  Module      : fft_twiddle_mult_cmul_round
//  Description : Two-stage complex multiplier with rounding and saturation.
//                Stage 1 registers the four partial products. Stage 2
//                registers the add/sub result after round-half-up and a clip
//                to the WIDTH-bit signed range. A valid bit runs alongside the
//                data, and the latency is fixed at 2 cycles.
//  Ports       :
//    clk      in   clock, rising edge
//    rst      in   synchronous active-high reset
//    valid_i  in   operand qualifier
//    a_re_i   in   sample real part      (signed WIDTH)
//    a_im_i   in   sample imaginary part (signed WIDTH)
//    b_re_i   in   twiddle real part     (signed WIDTH)
//    b_im_i   in   twiddle imag part     (signed WIDTH)
//    valid_o  out  result qualifier
//    re_o     out  rounded/saturated real part      (signed WIDTH)
//    im_o     out  rounded/saturated imaginary part (signed WIDTH)
//  Revision    : 1.0  initial release
// ============================================================================
module fft_twiddle_mult_cmul_round
  import fft_twiddle_mult_pkg::*;
#(
  parameter int WIDTH = c_width_dflt
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic signed [WIDTH-1:0] a_re_i,
  input  logic signed [WIDTH-1:0] a_im_i,
  input  logic signed [WIDTH-1:0] b_re_i,
  input  logic signed [WIDTH-1:0] b_im_i,
  output logic                    valid_o,
  output logic signed [WIDTH-1:0] re_o,
  output logic signed [WIDTH-1:0] im_o
);

  localparam int c_pw = 2 * WIDTH;   // product width
  localparam int c_sw = c_pw + 1;    // sum width, holds any ac-bd / ad+bc

  localparam logic signed [c_sw-1:0] c_round   = c_sw'(f_round_c(WIDTH));
  localparam logic signed [c_sw-1:0] c_sat_max = c_sw'(f_sat_max(WIDTH));
  localparam logic signed [c_sw-1:0] c_sat_min = c_sw'(f_sat_min(WIDTH));

  // Clip a shifted sum to the output range.
  function automatic logic signed [WIDTH-1:0] f_sat(
    input logic signed [c_sw-1:0] x
  );
    if (x > c_sat_max) begin
      return c_sat_max[WIDTH-1:0];
    end else if (x < c_sat_min) begin
      return c_sat_min[WIDTH-1:0];
    end
    return x[WIDTH-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // P2: partial products
  // --------------------------------------------------------------------------
  logic signed [c_pw-1:0] ac_q;
  logic signed [c_pw-1:0] bd_q;
  logic signed [c_pw-1:0] ad_q;
  logic signed [c_pw-1:0] bc_q;
  logic                   v2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ac_q <= '0;
      bd_q <= '0;
      ad_q <= '0;
      bc_q <= '0;
      v2_q <= 1'b0;
    end else begin
      // Widen before multiplying so the full product is kept.
      ac_q <= c_pw'(a_re_i) * c_pw'(b_re_i);
      bd_q <= c_pw'(a_im_i) * c_pw'(b_im_i);
      ad_q <= c_pw'(a_re_i) * c_pw'(b_im_i);
      bc_q <= c_pw'(a_im_i) * c_pw'(b_re_i);
      v2_q <= valid_i;
    end
  end

  // --------------------------------------------------------------------------
  // P3: add/sub, round, saturate
  // --------------------------------------------------------------------------
  logic signed [c_sw-1:0]  w_re_rnd;
  logic signed [c_sw-1:0]  w_im_rnd;
  logic signed [c_sw-1:0]  w_re_shr;
  logic signed [c_sw-1:0]  w_im_shr;
  logic signed [WIDTH-1:0] w_re_sat;
  logic signed [WIDTH-1:0] w_im_sat;

  always_comb begin
    w_re_rnd = c_sw'(ac_q) - c_sw'(bd_q) + c_round;
    w_im_rnd = c_sw'(ad_q) + c_sw'(bc_q) + c_round;
    // An arithmetic shift floors toward -inf, so with the added half-LSB
    // the result rounds half up.
    w_re_shr = w_re_rnd >>> (WIDTH - 1);
    w_im_shr = w_im_rnd >>> (WIDTH - 1);
    w_re_sat = f_sat(w_re_shr);
    w_im_sat = f_sat(w_im_shr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      re_o    <= '0;
      im_o    <= '0;
    end else begin
      valid_o <= v2_q;
      re_o    <= w_re_sat;
      im_o    <= w_im_sat;
    end
  end

endmodule : fft_twiddle_mult_cmul_round
`default_nettype wire

// File: rtl/fft_twiddle_mult.sv
`default_nettype none
// ============================================================================
//  Module      : fft_twiddle_mult
//  Description : Twiddle-multiply stage of a radix-2 DIT FFT.
//                - Counts butterflies within the current stage.
//                - Drives the twiddle ROM address combinationally.
//                - Registers the sample together with the returned twiddle
//                  (P1).
//                - Multiplies, rounds and saturates in the cmul_round sub-unit
//                  (P2/P3).
//                Latency is fixed at 3 cycles. There is no backpressure.
//  Ports       :
//    clk       in   clock, rising edge
//    rst       in   synchronous active-high reset
//    in_valid  in   sample qualifier
//    in_first  in   first sample of a stage (only meaningful with in_valid)
//    in_stage  in   stage index, clamped to N_LOG2-1
//    in_re     in   sample real part      (signed WIDTH)
//    in_im     in   sample imaginary part (signed WIDTH)
//    tw_addr   out  twiddle ROM address (combinational)
//    tw_re     in   twiddle cos term from the ROM
//    tw_im     in   twiddle -sin term from the ROM
//    out_valid out  result qualifier
//    out_re    out  product real part      (signed WIDTH)
//    out_im    out  product imaginary part (signed WIDTH)
//  Revision    : 1.0  initial release
// ============================================================================
module fft_twiddle_mult
  import fft_twiddle_mult_pkg::*;
#(
  parameter int WIDTH  = c_width_dflt,
  parameter int N_LOG2 = c_n_log2_dflt
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic [c_stage_w-1:0]    in_stage,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic [N_LOG2-1:0]       tw_addr,
  input  logic signed [WIDTH-1:0] tw_re,
  input  logic signed [WIDTH-1:0] tw_im,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int c_jw = N_LOG2 - 1;   // butterfly counter width

  // --------------------------------------------------------------------------
  // Butterfly counter / stage control
  // --------------------------------------------------------------------------
  logic [c_stage_w-1:0] stg_q;
  logic [c_stage_w-1:0] stg_d;
  logic [c_jw-1:0]      j_q;
  logic [c_jw-1:0]      j_d;

  logic                 w_first;
  logic [c_stage_w-1:0] w_stg_eff;
  logic [c_stage_w-1:0] w_shift;
  logic [c_jw-1:0]      w_j_eff;
  logic [c_jw-1:0]      w_mask;
  logic [c_jw-1:0]      w_j_next;

  always_comb begin
    w_first = in_valid & in_first;

    // A first-of-stage sample uses the new stage and j=0 in the same cycle,
    // so the ROM address is already correct for that sample.
    w_stg_eff = w_first ? f_clamp_stage(in_stage, N_LOG2 - 1) : stg_q;
    w_j_eff   = w_first ? '0 : j_q;

    // The stage has m = 2^stg butterflies, so the count wraps at m.
    w_mask   = c_jw'((32'd1 << w_stg_eff) - 32'd1);
    w_j_next = (w_j_eff + c_jw'(1)) & w_mask;

    stg_d = stg_q;
    j_d   = j_q;
    if (in_valid) begin
      stg_d = w_stg_eff;
      j_d   = w_j_next;
    end

    // k = j * N/2^(stg+1). j < 2^stg always holds, so the shifted value fits
    // in N_LOG2-1 bits and the MSB stays zero.
    w_shift = c_stage_w'(c_jw) - w_stg_eff;
    tw_addr = {1'b0, c_jw'(w_j_eff << w_shift)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q <= '0;
      j_q   <= '0;
    end else begin
      stg_q <= stg_d;
      j_q   <= j_d;
    end
  end

  // --------------------------------------------------------------------------
  // P1: sample + twiddle capture
  // --------------------------------------------------------------------------
  logic signed [WIDTH-1:0] a_re_q;
  logic signed [WIDTH-1:0] a_im_q;
  logic signed [WIDTH-1:0] b_re_q;
  logic signed [WIDTH-1:0] b_im_q;
  logic                    v1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_re_q <= '0;
      a_im_q <= '0;
      b_re_q <= '0;
      b_im_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      a_re_q <= in_re;
      a_im_q <= in_im;
      b_re_q <= tw_re;
      b_im_q <= tw_im;
      v1_q   <= in_valid;
    end
  end

  // --------------------------------------------------------------------------
  // P2/P3: complex multiply, round, saturate
  // --------------------------------------------------------------------------
  fft_twiddle_mult_cmul_round #(
    .WIDTH (WIDTH)
  ) u_cmul (
    .clk     (clk),
    .rst     (rst),
    .valid_i (v1_q),
    .a_re_i  (a_re_q),
    .a_im_i  (a_im_q),
    .b_re_i  (b_re_q),
    .b_im_i  (b_im_q),
    .valid_o (out_valid),
    .re_o    (out_re),
    .im_o    (out_im)
  );

endmodule : fft_twiddle_mult
`default_nettype wire

// File: tb/tb_fft_twiddle_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_twiddle_mult
//  Description : Self-checking bench for fft_twiddle_mult. A reference model
//                tracks the butterfly count, address and complex product, and
//                a queue of expected results is indexed by output cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_twiddle_mult;

  localparam int W  = 16;
  localparam int NL = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                in_valid;
  logic                in_first;
  logic [3:0]          in_stage;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic [NL-1:0]       tw_addr;
  logic signed [W-1:0] tw_re;
  logic signed [W-1:0] tw_im;
  logic                out_valid;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;

  fft_twiddle_mult #(
    .WIDTH  (W),
    .N_LOG2 (NL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_stage  (in_stage),
    .in_re     (in_re),
    .in_im     (in_im),
    .tw_addr   (tw_addr),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  typedef struct {
    int due;
    int re;
    int im;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int c;
    int d;
    int er;
    int ei;
  } vec_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   edge_n = 0;
  int   m_stg  = 0;
  int   m_j    = 0;
  int   seen_addr = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, req, edge_n);
  endtask

  // Exact real value scaled by 2^15, rounded half up (floor(x/2^15 + 1/2)),
  // then clipped to 16-bit range.
  function automatic int ref_q15(input longint x);
    longint y;
    longint qq;
    y  = x + 64'sd16384;
    qq = y / 64'sd32768;
    if (y < 0 && (y % 64'sd32768) != 0) qq = qq - 1;
    if (qq > 32767) qq = 32767;
    if (qq < -32768) qq = -32768;
    return int'(qq);
  endfunction

  // One clock cycle: drive inputs, check the address, advance the model and
  // check whatever the output should hold after the edge.
  task automatic tick(input bit r, input bit v, input bit f, input int stage,
                      input int a, input int b, input int c, input int d,
                      input bit use_exp, input int er, input int ei);
    int s;
    int j;
    rst      = r;
    in_valid = v;
    in_first = f;
    in_stage = 4'(stage);
    in_re    = W'(a);
    in_im    = W'(b);
    tw_re    = W'(c);
    tw_im    = W'(d);
    #3;
    seen_addr = int'(tw_addr);
    if (r) begin
      q.delete();
      m_stg = 0;
      m_j   = 0;
    end else if (v) begin
      if (f) begin
        s = (stage > NL - 1) ? NL - 1 : stage;
        j = 0;
      end else begin
        s = m_stg;
        j = m_j;
      end
      chk("tw_addr", tw_addr, j * (1 << (NL - 1 - s)));
      m_stg = s;
      m_j   = (j + 1) % (1 << s);
      if (use_exp)
        q.push_back('{edge_n + 3, er, ei});
      else
        q.push_back('{edge_n + 3,
                      ref_q15(longint'(a) * c - longint'(b) * d),
                      ref_q15(longint'(a) * d + longint'(b) * c)});
    end
    @(posedge clk);
    edge_n++;
    #1;
    if (q.size() > 0 && q[0].due == edge_n) begin
      chk("out_valid", out_valid, 1);
      chk("out_re", out_re, q[0].re);
      chk("out_im", out_im, q[0].im);
      void'(q.pop_front());
    end else begin
      chk("out_valid_idle", out_valid, 0);
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic tick_rand(input bit v, input bit f, input int stage);
    tick(1'b0, v, f, stage, rnd16(), rnd16(), rnd16(), rnd16(), 1'b0, 0, 0);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  vec_t tab[8];
  int   exp_stg1[4];

  initial begin
    // Directed product vectors: {a, b, c, d, expected re, expected im}
    tab[0] = '{16384, 0, 0, -32768, 0, -16384};
    tab[1] = '{-32768, -32768, 0, -32768, -32768, 32767};
    tab[2] = '{1, 0, 16384, 0, 1, 0};
    tab[3] = '{32767, 0, 32767, 0, 32766, 0};
    tab[4] = '{-32768, 0, -32768, 0, 32767, 0};
    tab[5] = '{0, 16384, 0, 16384, -8192, 0};
    tab[6] = '{3, 0, -16384, 0, -1, 0};
    tab[7] = '{1, 1, 16384, 16384, 0, 1};
    exp_stg1[0] = 0;
    exp_stg1[1] = 256;
    exp_stg1[2] = 0;
    exp_stg1[3] = 256;

    // Reset state
    tick(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
    tick(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    idle();
    chk("rst_tw_addr", tw_addr, 0);

    // Stage 1, four samples: address 0,256,0,256; first output 3 cycles on
    for (int i = 0; i < 4; i++) begin
      tick_rand(1'b1, i == 0, 1);
      chk("stg1_addr", seen_addr, exp_stg1[i]);
    end
    repeat (3) idle();

    // Directed product table at stage 0
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, i == 0, 0, tab[i].a, tab[i].b, tab[i].c, tab[i].d,
           1'b1, tab[i].er, tab[i].ei);
    end
    repeat (3) idle();

    // Stage 9: 512 continuous samples, then a 513th that wraps to 0
    for (int i = 0; i < 513; i++) begin
      tick_rand(1'b1, i == 0, 9);
      chk("stg9_addr", seen_addr, (i == 512) ? 0 : i);
    end

    // Bubbles: alternating valid in stage 3
    for (int i = 0; i < 8; i++) tick_rand(i % 2 == 0, i == 0, 3);
    repeat (3) idle();

    // Out-of-range stage clamps to the last stage
    tick_rand(1'b1, 1'b1, 15);
    tick_rand(1'b1, 1'b0, 0);
    chk("clamp_addr", seen_addr, 1);

    // Mid-stage in_first restarts the count
    tick_rand(1'b1, 1'b1, 2);
    tick_rand(1'b1, 1'b0, 0);
    tick_rand(1'b1, 1'b1, 2);
    chk("restart_addr", seen_addr, 0);
    tick_rand(1'b1, 1'b0, 0);
    chk("restart_next", seen_addr, 128);
    repeat (3) idle();

    // Reset while samples are in flight
    tick_rand(1'b1, 1'b1, 5);
    tick_rand(1'b1, 1'b0, 0);
    tick(1'b1, 1'b1, 1'b0, 0, 7, 7, 7, 7, 1'b0, 0, 0);
    chk("mid_rst_re", out_re, 0);
    chk("mid_rst_im", out_im, 0);
    repeat (4) idle();
    tick(1'b0, 1'b1, 1'b1, 0, 16384, 0, 0, -32768, 1'b1, 0, -16384);
    chk("post_rst_addr", seen_addr, 0);
    repeat (3) idle();

    // Random mixed traffic
    for (int i = 0; i < 300; i++) begin
      tick_rand($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                int'($urandom_range(0, 15)));
    end

    // Drain
    for (int i = 0; i < 6 && q.size() > 0; i++) idle();
    chk("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_fft_twiddle_mult
`default_nettype wire
